// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Instruction-memory request/response channel between the fetch
//             stage and instruction memory.
//  Signals  : imem_req_valid / imem_req_ready / imem_req_addr  (request)
//             imem_rsp_valid / imem_rsp_data                   (in-order response)
//  Modports : master - fetch side (drives requests, receives responses)
//             slave  - memory side
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDRESS_BITS = 16
);
    logic                    imem_req_valid;
    logic                    imem_req_ready;
    logic [ADDRESS_BITS-1:0] imem_req_addr;
    logic                    imem_rsp_valid;
    logic [31:0]             imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Owns the fetch PC, issues word-aligned
//             requests to instruction memory, buffers in-order responses in a
//             DEPTH-entry FIFO and presents the head PC/instruction to decode.
//             A redirect from decode flushes the FIFO and discards responses
//             that are still in flight for the old path.
//  Ports    : clock, reset        - clock, synchronous active-high reset
//             imem (master)       - instruction memory request/response
//             next_PC_select      - redirect request, qualified by a consume
//             target_PC           - redirect target
//             dec_ready           - decode accepts the head entry
//             instr_valid/PC/instruction - head entry towards decode
//             perf_fetched/perf_flushed  - only with FETCH_PERF_CNT_EN
//  Config   : FETCH_PERF_CNT_EN - adds fetched/flushed performance counters
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int                    ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC   = '0,
    parameter int                    DEPTH        = 2
) (
    input  wire logic                    clock,
    input  wire logic                    reset,
    fetch_unit_if.master                 imem,
    input  wire logic                    next_PC_select,
    input  wire logic [ADDRESS_BITS-1:0] target_PC,
    input  wire logic                    dec_ready,
    output logic                         instr_valid,
    output logic [ADDRESS_BITS-1:0]      PC,
    output logic [31:0]                  instruction
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_fetched,
    output logic [31:0]                  perf_flushed
`endif
);

    localparam int PW = $clog2(DEPTH);   // pointer width (DEPTH >= 2)
    localparam int CW = PW + 1;          // counter width, holds 0..DEPTH
    localparam int SW = CW + 1;          // headroom for count + outstanding
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

    // Registered state
    logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_BITS-1:0] last_pc_q;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           outstanding_q, outstanding_d;
    logic [CW-1:0]           discard_q, discard_d;
    logic [PW-1:0]           tag_rd_q, tag_rd_d;
    logic [PW-1:0]           tag_wr_q, tag_wr_d;

    logic [ADDRESS_BITS-1:0] fifo_pc_q   [DEPTH];
    logic [31:0]             fifo_data_q [DEPTH];
    logic [ADDRESS_BITS-1:0] tag_q       [DEPTH];

    // Combinational control
    logic          w_instr_valid;
    logic          w_pop;
    logic          w_redirect;
    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_rsp_keep;
    logic          w_rsp_discard;
    logic [SW-1:0] w_occupancy;

    assign w_instr_valid = (count_q != '0);
    assign w_pop         = w_instr_valid & dec_ready;
    assign w_redirect    = w_pop & next_PC_select;

    // The slot freed by this cycle's pop is credited immediately: its
    // replacement response cannot land before next cycle, which is what lets
    // a 2-deep FIFO sustain one instruction per cycle with a 1-cycle memory.
    assign w_occupancy   = SW'(count_q) + SW'(outstanding_q) - SW'(w_pop);
    assign w_req_valid   = !reset && (w_occupancy < SW'(DEPTH)) && !w_redirect;
    assign w_req_fire    = w_req_valid & imem.imem_req_ready;

    // A response is stale if earlier redirects still owe discards, or if it
    // lands in the redirect cycle itself (it belongs to the old path).
    assign w_rsp_keep    = imem.imem_rsp_valid && (discard_q == '0) && !w_redirect;
    assign w_rsp_discard = imem.imem_rsp_valid && (discard_q != '0);

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;

    assign instr_valid = w_instr_valid;
    assign PC          = w_instr_valid ? fifo_pc_q[rd_ptr_q] : last_pc_q;
    assign instruction = w_instr_valid ? fifo_data_q[rd_ptr_q] : NOP;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(w_req_fire) - CW'(imem.imem_rsp_valid);
        discard_d     = discard_q;
        count_d       = count_q + CW'(w_rsp_keep) - CW'(w_pop);
        rd_ptr_d      = rd_ptr_q + PW'(w_pop);
        wr_ptr_d      = wr_ptr_q + PW'(w_rsp_keep);
        tag_rd_d      = tag_rd_q + PW'(w_rsp_keep);
        tag_wr_d      = tag_wr_q + PW'(w_req_fire);

        if (w_req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(4);
        end
        if (w_rsp_discard) begin
            discard_d = discard_q - CW'(1);
        end

        if (w_redirect) begin
            // Everything still outstanding after this cycle belongs to the
            // old path. Discards carried over from an earlier redirect are
            // already part of outstanding, so the count simply replaces them.
            fetch_pc_d = target_PC & ALIGN_MASK;
            discard_d  = outstanding_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            last_pc_q     <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            if (w_pop) begin
                last_pc_q <= fifo_pc_q[rd_ptr_q];
            end
        end
    end

    // Storage arrays carry no reset; pointers and count define validity.
    always_ff @(posedge clock) begin
        if (w_req_fire) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
        if (w_rsp_keep) begin
            fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
            fifo_data_q[wr_ptr_q] <= imem.imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic [31:0] w_flush_inc;

    // On redirect every FIFO entry except the consumed head is thrown away,
    // plus a response landing in the same cycle.
    always_comb begin
        w_flush_inc = '0;
        if (w_redirect) begin
            w_flush_inc = 32'(count_q) - 32'd1 + 32'(imem.imem_rsp_valid);
        end else if (w_rsp_discard) begin
            w_flush_inc = 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(w_pop);
            perf_flushed_q <= perf_flushed_q + w_flush_inc;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A transaction-level model
//             tracks the architectural instruction stream (sequential PCs,
//             redirect targets), the expected request address sequence and an
//             in-order instruction memory with variable latency.
//  Config   : FETCH_PERF_CNT_EN - also checks the performance counters
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          AB    = 16;
    localparam logic [15:0] RPC   = 16'h0000;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        next_PC_select;
    logic [15:0] target_PC;
    logic        dec_ready;
    logic        instr_valid;
    logic [15:0] PC;
    logic [31:0] instruction;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_unit_if #(.ADDRESS_BITS(AB)) bus ();

    fetch_unit #(
        .ADDRESS_BITS (AB),
        .RESET_PC     (RPC),
        .DEPTH        (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem           (bus.master),
        .next_PC_select (next_PC_select),
        .target_PC      (target_PC),
        .dec_ready      (dec_ready),
        .instr_valid    (instr_valid),
        .PC             (PC),
        .instruction    (instruction)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a, ~a} ^ 32'h9E37_79B9;
    endfunction

    // Memory model: in-order queue of accepted addresses with due cycles
    logic [15:0] mq_addr[$];
    int          mq_due[$];
    int          last_due;
    int          now;

    // Architectural model
    logic [15:0] exp_pc;
    logic [15:0] next_req;
    bit          redir_prev;
    int          pops;
    int          fires;
    logic [15:0] prev_fire;
    bit          wrap_seen;

    // Stimulus controls
    int          p_dec, p_mready, p_redir, lat_min, lat_max;
    bit          force_en;
    logic [15:0] force_pc, force_target;

    // Last-cycle log
    bit          s_valid;
    logic [15:0] s_pc;
    logic [31:0] s_instr;

    function automatic logic [15:0] rand_target();
        if ($urandom_range(3) == 0) return 16'hFFF0 + 16'($urandom_range(15));
        return 16'($urandom_range(255));
    endfunction

    task automatic model_reset();
        mq_addr.delete();
        mq_due.delete();
        last_due   = 0;
        now        = 0;
        exp_pc     = RPC;
        next_req   = RPC;
        redir_prev = 1'b0;
        pops       = 0;
        fires      = 0;
        prev_fire  = 16'h0001;
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            reset              = 1'b1;
            dec_ready          = 1'($urandom_range(1));
            next_PC_select     = 1'($urandom_range(1));
            target_PC          = 16'($urandom);
            bus.imem_req_ready = 1'($urandom_range(1));
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
            #1;
            check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            if (k > 0) begin
                check("rst_instr_valid", 32'(instr_valid), 32'd0);
                check("rst_instruction", instruction, NOP);
                check("rst_pc", 32'(PC), 32'(RPC));
`ifdef FETCH_PERF_CNT_EN
                check("rst_perf_fetched", perf_fetched, 32'd0);
                check("rst_perf_flushed", perf_flushed, 32'd0);
`endif
            end
        end
        model_reset();
    endtask

    task automatic run_cycle();
        int  lat;
        int  due;
        bit  redirect;
        @(negedge clock);
        reset = 1'b0;
        now++;

        dec_ready      = ($urandom_range(99) < p_dec);
        next_PC_select = 1'b0;
        target_PC      = 16'($urandom);
        if (instr_valid && dec_ready) begin
            if (force_en && PC == force_pc) begin
                next_PC_select = 1'b1;
                target_PC      = force_target;
                force_en       = 1'b0;
            end else if ($urandom_range(99) < p_redir) begin
                next_PC_select = 1'b1;
                target_PC      = rand_target();
            end
        end else begin
            next_PC_select = 1'($urandom_range(1));   // must be ignored
        end

        bus.imem_req_ready = ($urandom_range(99) < p_mready);
        if (mq_due.size() > 0 && mq_due[0] <= now) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #1;

        redirect = instr_valid && dec_ready && next_PC_select;
        if (redir_prev) check("flush_valid", 32'(instr_valid), 32'd0);
        if (!instr_valid) check("nop_when_idle", instruction, NOP);
        if (redirect) check("req_in_redirect", 32'(bus.imem_req_valid), 32'd0);

        if (instr_valid && dec_ready) begin
            check("pc", 32'(PC), 32'(exp_pc));
            check("instr", instruction, mem_word(exp_pc));
            pops++;
            exp_pc = redirect ? (target_PC & 16'hFFFC) : exp_pc + 16'd4;
        end

        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", 32'(bus.imem_req_addr), 32'(next_req));
            if (prev_fire == 16'hFFFC && bus.imem_req_addr == 16'h0000) wrap_seen = 1'b1;
            prev_fire = bus.imem_req_addr;
            next_req  = next_req + 16'd4;
            fires++;
            lat = $urandom_range(lat_max, lat_min);
            due = now + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(bus.imem_req_addr);
            mq_due.push_back(due);
            check("outstanding_le_depth", 32'(mq_addr.size() > DEPTH), 32'd0);
        end
        if (redirect) next_req = target_PC & 16'hFFFC;
        redir_prev = redirect;

        s_valid = instr_valid;
        s_pc    = PC;
        s_instr = instruction;
    endtask

    bit          v_log [1:6];
    logic [15:0] pc_log[1:6];

    initial begin
        p_dec = 100; p_mready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
        force_en = 1'b0; force_pc = '0; force_target = '0; wrap_seen = 1'b0;
        model_reset();

        // 1) reset state, first-instruction latency, one instruction per cycle
        do_reset(2);
        for (int i = 1; i <= 6; i++) begin
            run_cycle();
            v_log[i]  = s_valid;
            pc_log[i] = s_pc;
        end
        check("lat_c2_invalid", 32'(v_log[2]), 32'd0);
        for (int i = 3; i <= 6; i++) begin
            check("ipc_valid", 32'(v_log[i]), 32'd1);
            check("ipc_pc", 32'(pc_log[i]), 32'(16'(4 * (i - 3))));
        end

        // 2) decode stalled: only DEPTH requests, head stable, nothing lost
        do_reset(2);
        p_dec = 0;
        repeat (8) run_cycle();
        check("stall_reqs", 32'(fires), 32'(DEPTH));
        check("stall_valid", 32'(s_valid), 32'd1);
        check("stall_pc", 32'(s_pc), 32'(RPC));
        check("stall_instr", s_instr, mem_word(RPC));
        p_dec = 100;

        // 3) redirect while consuming PC 8 to 0x42
        force_en = 1'b1; force_pc = 16'h0008; force_target = 16'h0042;
        for (int i = 0; i < 40 && force_en; i++) run_cycle();
        check("redir3_reached", 32'(force_en), 32'd0);
        check("redir3_next_req", 32'(next_req), 32'h0040);
        repeat (8) run_cycle();

        // 4) 3-cycle memory, redirect with requests in flight
        lat_min = 3; lat_max = 3;
        repeat (6) run_cycle();
        force_en = 1'b1; force_pc = exp_pc + 16'h0010; force_target = 16'h0100;
        for (int i = 0; i < 80 && force_en; i++) run_cycle();
        check("redir4_reached", 32'(force_en), 32'd0);
        repeat (20) run_cycle();

        // 5) redirect near the top of the address space, fetch wraps to 0
        lat_min = 1; lat_max = 1;
        force_en = 1'b1; force_pc = exp_pc + 16'h0008; force_target = 16'hFFFE;
        for (int i = 0; i < 80 && force_en; i++) run_cycle();
        check("redir5_reached", 32'(force_en), 32'd0);
        repeat (10) run_cycle();
        check("wrap_seen", 32'(wrap_seen), 32'd1);

        // 6) reset with the FIFO full and no requests in flight
        p_dec = 0;
        repeat (10) run_cycle();
        check("full_valid", 32'(s_valid), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'(pops));
`endif
        do_reset(2);
        p_dec = 100;
        repeat (6) run_cycle();

        // Randomized phases
        p_redir = 10;
        for (int ph = 0; ph < 4; ph++) begin
            lat_min  = 1;
            lat_max  = 1 + ph;
            p_dec    = 50 + 15 * ph;
            p_mready = 95 - 15 * ph;
            repeat (800) run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
